// File: rtl/exp_host_pkg.sv
// Shared types and constants for the montgomery_exp host sequencer.
package exp_host_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int OP_W_DEF   = 512;
  localparam int NUM_OPS    = 5;

  // Operand slots, in the order they arrive on the input stream
  localparam int OP_X     = 0;
  localparam int OP_E     = 1;
  localparam int OP_M     = 2;
  localparam int OP_RMODM = 3;
  localparam int OP_R2    = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT,
    DRAIN
  } state_e;

endpackage

// File: rtl/exp_result_serializer.sv
// Parallel-load shift register that emits an OP_W value as DATA_W words,
// least-significant word first, over a valid/ready stream.
module exp_result_serializer #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 512
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_i,
  input  logic [OP_W-1:0]   data_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              last_o
);

  localparam int WPO = OP_W / DATA_W;
  localparam int CW  = (WPO > 1) ? $clog2(WPO) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WPO - 1);

  logic [OP_W-1:0] shreg_q, shreg_d;
  logic            valid_q, valid_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hs;

  assign hs          = valid_q & out_ready_i;
  assign last_o      = hs && (cnt_q == LAST_WORD);
  assign out_data_o  = shreg_q[DATA_W-1:0];
  assign out_valid_o = valid_q;

  always_comb begin
    shreg_d = shreg_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      shreg_d = data_i;
      valid_d = 1'b1;
      cnt_d   = '0;
    end else if (hs) begin
      shreg_d = shreg_q >> DATA_W;
      cnt_d   = cnt_q + CW'(1);
      if (last_o) begin
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      shreg_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/exp_host_sequencer.sv
// Host sequencer for montgomery_exp: loads five operands from a word stream, pulses
// start, waits for done and streams the result out. Optional watchdog: EXP_WATCHDOG_EN.
module exp_host_sequencer
  import exp_host_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int OP_W        = OP_W_DEF,
  parameter int WDOG_CYCLES = 2000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err,
  output logic              exp_start,
  output logic [OP_W-1:0]   exp_x,
  output logic [OP_W-1:0]   exp_e,
  output logic [OP_W-1:0]   exp_m,
  output logic [OP_W-1:0]   exp_rmodm,
  output logic [OP_W-1:0]   exp_r2modm,
  input  logic [OP_W-1:0]   exp_result,
  input  logic              exp_done
);

  localparam int WPO = OP_W / DATA_W;
  localparam int WCW = (WPO > 1) ? $clog2(WPO) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(WPO - 1);
  localparam logic [2:0]     LAST_OP   = 3'(NUM_OPS - 1);

  state_e          state_q, state_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic [2:0]      op_cnt_q, op_cnt_d;
  logic [OP_W-1:0] ops_q [NUM_OPS];
  logic [OP_W-1:0] ops_d [NUM_OPS];
  logic            in_ready_q, in_ready_d;
  logic            err_q, err_d;
  logic            load_hs;
  logic            ser_load;
  logic            ser_last;

`ifdef EXP_WATCHDOG_EN
  logic [31:0] wdog_q, wdog_d;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES != 0);
`endif

  assign load_hs = in_valid & in_ready_q;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    op_cnt_d   = op_cnt_q;
    err_d      = err_q;
    ser_load   = 1'b0;
    exp_start  = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) ops_d[i] = ops_q[i];
`ifdef EXP_WATCHDOG_EN
    wdog_d = wdog_q;
`endif

    // in_ready is only ever high in IDLE/LOAD, so this covers both states
    if (load_hs) begin
      ops_d[op_cnt_q][word_cnt_q*DATA_W +: DATA_W] = in_data;
      if (word_cnt_q == LAST_WORD) begin
        word_cnt_d = '0;
        if (op_cnt_q == LAST_OP) begin
          op_cnt_d = '0;
          state_d  = START;
        end else begin
          op_cnt_d = op_cnt_q + 3'd1;
          state_d  = LOAD;
        end
      end else begin
        word_cnt_d = word_cnt_q + WCW'(1);
        state_d    = LOAD;
      end
    end

    case (state_q)
      START: begin
        exp_start = 1'b1;
        state_d   = WAIT;
`ifdef EXP_WATCHDOG_EN
        wdog_d = '0;
`endif
      end
      WAIT: begin
        if (exp_done) begin
          ser_load = 1'b1;
          state_d  = DRAIN;
        end
`ifdef EXP_WATCHDOG_EN
        else begin
          wdog_d = wdog_q + 32'd1;
          if (wdog_d == 32'(WDOG_CYCLES)) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
`endif
      end
      DRAIN: begin
        if (ser_last) state_d = IDLE;
      end
      default: ;
    endcase

    // Registered so the port reads 0 during reset and drops the cycle after the last word
    in_ready_d = ((state_d == IDLE) && !err_d) || (state_d == LOAD);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      op_cnt_q   <= '0;
      in_ready_q <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      op_cnt_q   <= op_cnt_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
      for (int i = 0; i < NUM_OPS; i++) ops_q[i] <= ops_d[i];
    end
  end

`ifdef EXP_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (!resetn) wdog_q <= '0;
    else         wdog_q <= wdog_d;
  end
`endif

  exp_result_serializer #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_ser (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (ser_load),
    .data_i      (exp_result),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .last_o      (ser_last)
  );

  assign in_ready   = in_ready_q;
  assign err        = err_q;
  assign busy       = (state_q != IDLE);
  assign exp_x      = ops_q[OP_X];
  assign exp_e      = ops_q[OP_E];
  assign exp_m      = ops_q[OP_M];
  assign exp_rmodm  = ops_q[OP_RMODM];
  assign exp_r2modm = ops_q[OP_R2];

endmodule

// File: tb/tb_exp_host_sequencer.sv
// Self-checking bench for exp_host_sequencer with a stub core; a transaction-level
// model is compared every cycle. Define EXP_WATCHDOG_EN to also exercise the watchdog.
module tb_exp_host_sequencer;

  localparam int DATA_W = 32;
  localparam int OP_W   = 512;
  localparam int WPO    = OP_W / DATA_W;
  localparam int NOPS   = 5;
  localparam int TOTAL  = NOPS * WPO;
  localparam int WDOG   = 100;
  localparam int HALF   = 5;
  localparam int PH_LOAD = 0, PH_START = 1, PH_WAIT = 2, PH_DRAIN = 3, PH_HALT = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              err;
  logic              exp_start;
  logic [OP_W-1:0]   exp_x, exp_e, exp_m, exp_rmodm, exp_r2modm;
  logic [OP_W-1:0]   exp_result;
  logic              exp_done;

  int testsRun = 0;
  int testsFailed = 0;

  logic [OP_W-1:0]   curOps [NOPS];
  logic [OP_W-1:0]   stubRes;
  logic              stubEn;
  int                stubLat;
  int                staleReq = 0;
  logic              chkEn = 1'b0;
  int                startSeen = 0;
  time               tStart = 0;
  time               tHs = 0;
  logic [OP_W-1:0]   eAtStart = '0;
  logic [DATA_W-1:0] obsQ [$];

  int                mPhase = PH_LOAD;
  int                mAcc = 0;
  int                mWd = 0;
  logic              mRdy = 1'b0;
  logic              mErr = 1'b0;
  logic [OP_W-1:0]   mOps [NOPS];
  logic [DATA_W-1:0] mQ [$];

  assign exp_result = stubRes;

  always #HALF clk = ~clk;

  exp_host_sequencer #(
    .DATA_W      (DATA_W),
    .OP_W        (OP_W),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .err        (err),
    .exp_start  (exp_start),
    .exp_x      (exp_x),
    .exp_e      (exp_e),
    .exp_m      (exp_m),
    .exp_rmodm  (exp_rmodm),
    .exp_r2modm (exp_r2modm),
    .exp_result (exp_result),
    .exp_done   (exp_done)
  );

  task automatic checkOutput(input string name, input logic [OP_W-1:0] act, input logic [OP_W-1:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [OP_W-1:0] mkOp(input logic [31:0] top, input logic [31:0] bot, input logic [31:0] seed);
    logic [OP_W-1:0] r;
    r = '0;
    for (int i = 0; i < WPO; i++) r[i*DATA_W +: DATA_W] = (seed * 32'(i + 3)) ^ 32'(i << 20);
    r[DATA_W-1:0] = bot;
    r[OP_W-1 -: DATA_W] = top;
    return r;
  endfunction

  // Transaction-level model: words are accepted in stream order, 80 of them make a run
  always @(posedge clk) begin
    if (!resetn) begin
      mPhase = PH_LOAD;
      mAcc   = 0;
      mWd    = 0;
      mRdy   = 1'b0;
      mErr   = 1'b0;
      mQ.delete();
      for (int i = 0; i < NOPS; i++) mOps[i] = '0;
    end else begin
      case (mPhase)
        PH_LOAD: if (in_valid && mRdy) begin
          mOps[mAcc / WPO][(mAcc % WPO)*DATA_W +: DATA_W] = in_data;
          mAcc++;
          if (mAcc == TOTAL) begin
            mAcc   = 0;
            mPhase = PH_START;
          end
        end
        PH_START: begin
          mPhase = PH_WAIT;
          mWd    = 0;
        end
        PH_WAIT: begin
          if (exp_done) begin
            for (int i = 0; i < WPO; i++) mQ.push_back(exp_result[i*DATA_W +: DATA_W]);
            mPhase = PH_DRAIN;
          end
`ifdef EXP_WATCHDOG_EN
          else begin
            mWd++;
            if (mWd == WDOG) begin
              mErr   = 1'b1;
              mPhase = PH_HALT;
            end
          end
`endif
        end
        PH_DRAIN: if (out_ready && mQ.size() > 0) begin
          void'(mQ.pop_front());
          if (mQ.size() == 0) mPhase = PH_LOAD;
        end
        default: ;
      endcase
      mRdy = (mPhase == PH_LOAD);
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      checkOutput("in_ready", OP_W'(in_ready), OP_W'(mRdy));
      checkOutput("busy", OP_W'(busy), OP_W'((mAcc > 0) || (mPhase == PH_START) || (mPhase == PH_WAIT) || (mPhase == PH_DRAIN)));
      checkOutput("out_valid", OP_W'(out_valid), OP_W'(mPhase == PH_DRAIN));
      if (mPhase == PH_DRAIN && mQ.size() > 0) checkOutput("out_data", OP_W'(out_data), OP_W'(mQ[0]));
      checkOutput("exp_start", OP_W'(exp_start), OP_W'(mPhase == PH_START));
      checkOutput("err", OP_W'(err), OP_W'(mErr));
      checkOutput("exp_x", exp_x, mOps[0]);
      checkOutput("exp_e", exp_e, mOps[1]);
      checkOutput("exp_m", exp_m, mOps[2]);
      checkOutput("exp_rmodm", exp_rmodm, mOps[3]);
      checkOutput("exp_r2modm", exp_r2modm, mOps[4]);
      if (out_valid && out_ready) obsQ.push_back(out_data);
      if (exp_start) begin
        startSeen++;
        tStart   = $time;
        eAtStart = exp_e;
      end
    end
  end

  // Stub core: done LAT cycles after start; staleReq injects a spurious done pulse
  initial begin
    int cnt;
    int staleSeen;
    cnt = 0;
    staleSeen = 0;
    exp_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      exp_done = 1'b0;
      if (staleReq != staleSeen) begin
        exp_done  = 1'b1;
        staleSeen = staleReq;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) exp_done = 1'b1;
      end else if (exp_start && stubEn) begin
        cnt = stubLat;
      end
    end
  end

  task automatic doReset(input int cycles);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    chkEn = 1'b1;
    checkOutput("rst_in_ready", OP_W'(in_ready), '0);
    checkOutput("rst_out_valid", OP_W'(out_valid), '0);
    checkOutput("rst_out_data", OP_W'(out_data), '0);
    checkOutput("rst_busy", OP_W'(busy), '0);
    checkOutput("rst_err", OP_W'(err), '0);
    checkOutput("rst_exp_start", OP_W'(exp_start), '0);
    checkOutput("rst_exp_x", exp_x, '0);
    checkOutput("rst_exp_r2modm", exp_r2modm, '0);
    repeat (cycles - 1) begin
      @(posedge clk);
      #1;
    end
    resetn = 1'b1;
  endtask

  task automatic applyStimulus(input int nWords, input int gap);
    for (int w = 0; w < nWords; w++) begin
      int guard;
      logic acc;
      in_data  = curOps[w / WPO][(w % WPO)*DATA_W +: DATA_W];
      in_valid = 1'b1;
      guard    = 0;
      do begin
        acc = in_ready;
        @(posedge clk);
        if (acc) tHs = $time;
        #1;
        guard++;
      end while (!acc && guard < 200);
      checkOutput("word_accepted", OP_W'(acc), OP_W'(1));
      if (gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic finishRun(input int stallAt, input int stallLen);
    int guard;
    logic stalled;
    guard   = 0;
    stalled = 1'b0;
    out_ready = 1'b1;
    while (busy && guard < 5000) begin
      if (!stalled && out_valid && obsQ.size() == stallAt) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        repeat (stallLen) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("run_completes", OP_W'(busy), '0);
  endtask

  task automatic doRun(input string tag, input int gap, input int stallAt, input int stallLen,
                       input logic [OP_W-1:0] eLit, input logic [31:0] firstLit, input logic [31:0] lastLit);
    int starts0;
    starts0 = startSeen;
    obsQ.delete();
    applyStimulus(TOTAL, gap);
    finishRun(stallAt, stallLen);
    checkOutput({tag, "_start_pulses"}, OP_W'(startSeen - starts0), OP_W'(1));
    checkOutput({tag, "_start_delay"}, OP_W'(tStart - tHs), OP_W'(HALF));
    checkOutput({tag, "_e_at_start"}, eAtStart, eLit);
    checkOutput({tag, "_word_count"}, OP_W'(obsQ.size()), OP_W'(WPO));
    if (obsQ.size() > 0) begin
      checkOutput({tag, "_first_word"}, OP_W'(obsQ[0]), OP_W'(firstLit));
      checkOutput({tag, "_last_word"}, OP_W'(obsQ[obsQ.size()-1]), OP_W'(lastLit));
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 400000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [OP_W-1:0] xA, eA, mA, rmA, r2A, xB2;
    int starts0;
    xA  = mkOp(32'hb55708a7, 32'h5e31ba76, 32'h9e3779b9);
    eA  = 512'hb1;
    mA  = mkOp(32'hd9bf2caa, 32'h7c01419f, 32'h85ebca6b);
    rmA = mkOp(32'h2640d355, 32'h0a4dbe61, 32'hc2b2ae35);
    r2A = mkOp(32'h11b88806, 32'h3fe70420, 32'h27d4eb2f);
    xB2 = mkOp(32'h0badf00d, 32'hdeadbeef, 32'h165667b1);
    curOps[0] = xA;
    curOps[1] = eA;
    curOps[2] = mA;
    curOps[3] = rmA;
    curOps[4] = r2A;
    stubRes   = mkOp(32'h1f5ecf6f, 32'h9c3a1fcb, 32'h61c88647);
    stubEn    = 1'b1;
    stubLat   = 50;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    doReset(3);
    doRun("basic", 0, -1, 0, 512'hb1, 32'h9c3a1fcb, 32'h1f5ecf6f);
    checkOutput("basic_x_held", exp_x, xA);
    doRun("gapped", 1, -1, 0, 512'hb1, 32'h9c3a1fcb, 32'h1f5ecf6f);
    doRun("stall", 0, 3, 20, 512'hb1, 32'h9c3a1fcb, 32'h1f5ecf6f);

    starts0 = startSeen;
    applyStimulus(37, 0);
    doReset(2);
    checkOutput("abort_no_start", OP_W'(startSeen - starts0), '0);
    staleReq++;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checkOutput("stale_busy", OP_W'(busy), '0);
    checkOutput("stale_out_valid", OP_W'(out_valid), '0);
    doRun("after_abort", 0, -1, 0, 512'hb1, 32'h9c3a1fcb, 32'h1f5ecf6f);

    curOps[1] = 512'h1;
    doRun("b2b_first", 0, -1, 0, 512'h1, 32'h9c3a1fcb, 32'h1f5ecf6f);
    curOps[0] = xB2;
    curOps[1] = 512'h3;
    doRun("b2b_second", 0, -1, 0, 512'h3, 32'h9c3a1fcb, 32'h1f5ecf6f);
    checkOutput("b2b_x_replaced", exp_x, xB2);
    checkOutput("b2b_e_replaced", exp_e, 512'h3);

`ifdef EXP_WATCHDOG_EN
    stubEn = 1'b0;
    obsQ.delete();
    applyStimulus(TOTAL, 0);
    repeat (WDOG + 10) begin
      @(posedge clk);
      #1;
    end
    checkOutput("wdog_err", OP_W'(err), OP_W'(1));
    checkOutput("wdog_in_ready", OP_W'(in_ready), '0);
    checkOutput("wdog_no_words", OP_W'(obsQ.size()), '0);
    in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("wdog_halted", OP_W'(in_ready), '0);
    doReset(2);
    @(posedge clk);
    #1;
    checkOutput("wdog_cleared_err", OP_W'(err), '0);
    checkOutput("wdog_cleared_ready", OP_W'(in_ready), OP_W'(1));
    stubEn = 1'b1;
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
